multicycle_ctrl_unit: RTL

Multi-cycle control FSM for the RV32I core; successor to the single-cycle control decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. Waits on instruction and data memory ready handshakes, with a bounded timeout. Drives the same datapath selects, widened where RV32I needs more sources, and adds a retired-instruction counter and trap reporting for illegal opcodes and memory timeouts.

---
 rtl/multicycle_ctrl_unit.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with ready
// timeouts, trap reporting and a retired-instruction counter.
//
// Ports:
//   clk, rst        - clock, async active-low reset
//   opcode          - IR[6:0], valid from DECODE onward
//   branch_taken    - ALU branch compare, valid in EXEC
//   imem_ready      - instruction memory data valid
//   dmem_ready      - data memory access complete
//   IM_read_en      - fetch request
//   IR_load         - latch fetched word into IR
//   DM_read_en      - data read request (MEM, loads)
//   DM_write_en     - data write request (MEM, stores)
//   port_A_sel      - ALU A: 00 rs1, 01 PC, 10 zero
//   port_B_sel      - ALU B: 0 rs2, 1 imm
//   imm_en          - immediate generator enable
//   write_MUX_sel   - RF data: 00 ALU, 01 DM, 10 PC+4
//   PC_MUX_sel      - next PC: 0 PC+4, 1 ALU result
//   PC_write        - PC load
//   reg_write_en    - RF write
//   trap            - sticky fault flag
//   trap_cause      - 01 illegal, 10 imem timeout, 11 dmem timeout
//   instret_count   - retired instructions
module multicycle_ctrl_unit #(
  parameter int WIDTH       = 32,
  parameter int OPCODE_W    = 7,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                branch_taken,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                IM_read_en,
  output logic                IR_load,
  output logic                DM_read_en,
  output logic                DM_write_en,
  output logic [1:0]          port_A_sel,
  output logic                port_B_sel,
  output logic                imm_en,
  output logic [1:0]          write_MUX_sel,
  output logic                PC_MUX_sel,
  output logic                PC_write,
  output logic                reg_write_en,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [WIDTH-1:0]    instret_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LIM = CW'(MEM_TIMEOUT - 1);

  localparam logic [OPCODE_W-1:0] OC_LUI   = OPCODE_W'(7'b0110111);
  localparam logic [OPCODE_W-1:0] OC_AUIPC = OPCODE_W'(7'b0010111);
  localparam logic [OPCODE_W-1:0] OC_JAL   = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OC_JALR  = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OC_BR    = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OC_LD    = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OC_ST    = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OC_OPI   = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OC_OP    = OPCODE_W'(7'b0110011);

  state_t              state;
  logic [OPCODE_W-1:0] opcode_q;
  logic [CW-1:0]       wait_cnt;

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_op;
  logic legal, retire;

  assign is_lui   = (opcode_q == OC_LUI);
  assign is_auipc = (opcode_q == OC_AUIPC);
  assign is_jal   = (opcode_q == OC_JAL);
  assign is_jalr  = (opcode_q == OC_JALR);
  assign is_br    = (opcode_q == OC_BR);
  assign is_ld    = (opcode_q == OC_LD);
  assign is_st    = (opcode_q == OC_ST);
  assign is_op    = (opcode_q == OC_OP);

  // Legality is judged on the live IR field while in DECODE.
  assign legal = (opcode == OC_LUI)  || (opcode == OC_AUIPC) ||
                 (opcode == OC_JAL)  || (opcode == OC_JALR)  ||
                 (opcode == OC_BR)   || (opcode == OC_LD)    ||
                 (opcode == OC_ST)   || (opcode == OC_OPI)   ||
                 (opcode == OC_OP);

  assign retire = (state == S_WB) ||
                  (state == S_EXEC && is_br) ||
                  (state == S_MEM && is_st && dmem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_FETCH;
      opcode_q      <= '0;
      wait_cnt      <= '0;
      instret_count <= '0;
      trap          <= 1'b0;
      trap_cause    <= 2'b00;
    end else begin
      unique case (state)
        S_FETCH: begin
          // Ready on the limit cycle wins over the timeout.
          if (imem_ready) begin
            state    <= S_DECODE;
            wait_cnt <= '0;
          end else if (wait_cnt == LIM) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          opcode_q <= opcode;
          if (legal) begin
            state <= S_EXEC;
          end else begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b01;
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (is_br)              state <= S_FETCH;
          else if (is_ld || is_st) state <= S_MEM;
          else                    state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            wait_cnt <= '0;
            state    <= is_st ? S_FETCH : S_WB;
          end else if (wait_cnt == LIM) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b11;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_WB: state <= S_FETCH;
        default: state <= S_TRAP;
      endcase
      if (retire)
        instret_count <= instret_count + WIDTH'(1);
    end
  end

  // Control decode; held low while reset is asserted so that a
  // mid-access reset drops enables without waiting for a clock.
  always_comb begin
    IM_read_en    = 1'b0;
    IR_load       = 1'b0;
    DM_read_en    = 1'b0;
    DM_write_en   = 1'b0;
    port_A_sel    = 2'b00;
    port_B_sel    = 1'b0;
    imm_en        = 1'b0;
    write_MUX_sel = 2'b00;
    PC_MUX_sel    = 1'b0;
    PC_write      = 1'b0;
    reg_write_en  = 1'b0;
    if (rst) begin
      unique case (state)
        S_FETCH: begin
          IM_read_en = 1'b1;
          IR_load    = imem_ready;
        end
        S_DECODE: imm_en = 1'b1;
        S_EXEC: begin
          unique case (1'b1)
            is_op: begin
              port_A_sel = 2'b00;
              port_B_sel = 1'b0;
            end
            is_lui: begin
              port_A_sel = 2'b10;
              port_B_sel = 1'b1;
            end
            is_auipc, is_jal: begin
              port_A_sel = 2'b01;
              port_B_sel = 1'b1;
            end
            is_br: begin
              port_A_sel = 2'b01;
              port_B_sel = 1'b1;
              PC_write   = 1'b1;
              PC_MUX_sel = branch_taken;
            end
            default: begin
              port_A_sel = 2'b00;
              port_B_sel = 1'b1;
            end
          endcase
        end
        S_MEM: begin
          DM_read_en  = is_ld;
          DM_write_en = is_st;
          PC_write    = is_st && dmem_ready;
        end
        S_WB: begin
          reg_write_en = 1'b1;
          PC_write     = 1'b1;
          PC_MUX_sel   = is_jal || is_jalr;
          if (is_ld)
            write_MUX_sel = 2'b01;
          else if (is_jal || is_jalr)
            write_MUX_sel = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule
